ps2_kbd_init_ctrl: RTL

//   Host-side sequencer for the PS/2 keyboard path. It sits between the game logic and PS2_Controller.

---
 rtl/ps2_kbd_init_ctrl_if.sv | 28 ++
 rtl/ps2_kbd_init_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_init_ctrl_if.sv
// PS/2 host byte-level bus between the init sequencer and PS2_Controller.
// master: sequencer side (drives cmd/send); slave: controller side.
interface ps2_kbd_init_ctrl_if;
  logic [7:0] ps2_cmd;
  logic       ps2_send;
  logic       ps2_cmd_sent;
  logic       ps2_tx_timeout;
  logic [7:0] ps2_rx_data;
  logic       ps2_rx_en;

  modport master (
    output ps2_cmd,
    output ps2_send,
    input  ps2_cmd_sent,
    input  ps2_tx_timeout,
    input  ps2_rx_data,
    input  ps2_rx_en
  );

  modport slave (
    input  ps2_cmd,
    input  ps2_send,
    output ps2_cmd_sent,
    output ps2_tx_timeout,
    output ps2_rx_data,
    output ps2_rx_en
  );
endinterface

// File: rtl/ps2_kbd_init_ctrl.sv
// PS/2 keyboard init sequencer: reset/BAT, typematic, enable, LED updates.
// Ports: CLOCK_50/resetn, ps2 bus (master), led_req/mask/ack, key_*, ready, fail.
module ps2_kbd_init_ctrl #(
  parameter logic [7:0]  TYPEMATIC = 8'h20,
  parameter int unsigned TIMEOUT   = 50_000_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  ps2_kbd_init_ctrl_if.master ps2,
  input  logic       led_req,
  input  logic [2:0] led_mask,
  output logic       led_ack,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic       ready,
  output logic       fail
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  localparam logic [7:0] B_RST = 8'hFF;
  localparam logic [7:0] B_RATE = 8'hF3;
  localparam logic [7:0] B_EN  = 8'hF4;
  localparam logic [7:0] B_LED = 8'hED;
  localparam logic [7:0] B_ACK = 8'hFA;
  localparam logic [7:0] B_NAK = 8'hFE;
  localparam logic [7:0] B_BAT = 8'hAA;
  localparam logic [7:0] B_BF  = 8'hFC;

  typedef enum logic [4:0] {
    RST_TX,
    RST_WS,
    RST_ACK,
    BAT,
    RATE_TX,
    RATE_WS,
    RATE_ACK,
    PARM_TX,
    PARM_WS,
    PARM_ACK,
    EN_TX,
    EN_WS,
    EN_ACK,
    READY,
    LED_TX,
    LED_WS,
    LED_ACK,
    MSK_TX,
    MSK_WS,
    MSK_ACK,
    FAIL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic [RW-1:0] retry_nxt;
  logic [2:0]    mask_q;
  logic [2:0]    mask_nxt;
  logic [7:0]    cmd_nxt;
  logic          send_nxt;
  logic          ack_nxt;
  logic          fwd;
  logic          err;

  logic is_wait;
  logic led_path;
  logic expired;
  logic rx_fa;
  logic rx_fe;
  logic rx_aa;
  logic rx_fc;
  logic ws_err;
  logic ack_err;
  logic bat_err;

  assign is_wait = state inside {
    RST_WS, RST_ACK, BAT,
    RATE_WS, RATE_ACK,
    PARM_WS, PARM_ACK,
    EN_WS, EN_ACK,
    LED_WS, LED_ACK,
    MSK_WS, MSK_ACK
  };

  assign led_path = state inside {
    LED_TX, LED_WS, LED_ACK,
    MSK_TX, MSK_WS, MSK_ACK
  };

  assign expired = is_wait && (timer == T_LAST);

  assign rx_fa = ps2.ps2_rx_en && (ps2.ps2_rx_data == B_ACK);
  assign rx_fe = ps2.ps2_rx_en && (ps2.ps2_rx_data == B_NAK);
  assign rx_aa = ps2.ps2_rx_en && (ps2.ps2_rx_data == B_BAT);
  assign rx_fc = ps2.ps2_rx_en && (ps2.ps2_rx_data == B_BF);

  // A transmit timeout beats a simultaneous cmd_sent.
  assign ws_err  = expired | ps2.ps2_tx_timeout;
  assign ack_err = expired | rx_fe;
  assign bat_err = expired | rx_fc;

  // Keystrokes arriving during an LED update must not be dropped.
  always_comb begin
    fwd = 1'b0;
    unique case (1'b1)
      (state == READY): fwd = ps2.ps2_rx_en;
      led_path:         fwd = ps2.ps2_rx_en && !rx_fa && !rx_fe;
      default:          fwd = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    mask_nxt  = mask_q;
    cmd_nxt   = ps2.ps2_cmd;
    send_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    err       = 1'b0;
    unique case (state)
      RST_TX: begin
        cmd_nxt   = B_RST;
        send_nxt  = 1'b1;
        state_nxt = RST_WS;
      end
      RST_WS: begin
        if (ws_err) err = 1'b1;
        else if (ps2.ps2_cmd_sent) state_nxt = RST_ACK;
      end
      RST_ACK: begin
        if (ack_err) err = 1'b1;
        else if (rx_fa) state_nxt = BAT;
      end
      BAT: begin
        if (bat_err) err = 1'b1;
        else if (rx_aa) state_nxt = RATE_TX;
      end
      RATE_TX: begin
        cmd_nxt   = B_RATE;
        send_nxt  = 1'b1;
        state_nxt = RATE_WS;
      end
      RATE_WS: begin
        if (ws_err) err = 1'b1;
        else if (ps2.ps2_cmd_sent) state_nxt = RATE_ACK;
      end
      RATE_ACK: begin
        if (ack_err) err = 1'b1;
        else if (rx_fa) state_nxt = PARM_TX;
      end
      PARM_TX: begin
        cmd_nxt   = TYPEMATIC;
        send_nxt  = 1'b1;
        state_nxt = PARM_WS;
      end
      PARM_WS: begin
        if (ws_err) err = 1'b1;
        else if (ps2.ps2_cmd_sent) state_nxt = PARM_ACK;
      end
      PARM_ACK: begin
        if (ack_err) err = 1'b1;
        else if (rx_fa) state_nxt = EN_TX;
      end
      EN_TX: begin
        cmd_nxt   = B_EN;
        send_nxt  = 1'b1;
        state_nxt = EN_WS;
      end
      EN_WS: begin
        if (ws_err) err = 1'b1;
        else if (ps2.ps2_cmd_sent) state_nxt = EN_ACK;
      end
      EN_ACK: begin
        if (ack_err) err = 1'b1;
        else if (rx_fa) state_nxt = READY;
      end
      READY: begin
        // Skipping the ack cycle stops a held request re-firing.
        if (led_req && !led_ack) begin
          mask_nxt  = led_mask;
          state_nxt = LED_TX;
        end
      end
      LED_TX: begin
        cmd_nxt   = B_LED;
        send_nxt  = 1'b1;
        state_nxt = LED_WS;
      end
      LED_WS: begin
        if (ws_err) err = 1'b1;
        else if (ps2.ps2_cmd_sent) state_nxt = LED_ACK;
      end
      LED_ACK: begin
        if (ack_err) err = 1'b1;
        else if (rx_fa) state_nxt = MSK_TX;
      end
      MSK_TX: begin
        cmd_nxt   = {5'b0, mask_q};
        send_nxt  = 1'b1;
        state_nxt = MSK_WS;
      end
      MSK_WS: begin
        if (ws_err) err = 1'b1;
        else if (ps2.ps2_cmd_sent) state_nxt = MSK_ACK;
      end
      MSK_ACK: begin
        if (ack_err) err = 1'b1;
        else if (rx_fa) begin
          ack_nxt   = 1'b1;
          state_nxt = READY;
        end
      end
      FAIL: state_nxt = FAIL;
      default: state_nxt = RST_TX;
    endcase

    if (err) begin
      retry_nxt = retry + 1'b1;
      if (retry_nxt == R_MAX) state_nxt = FAIL;
      else if (led_path) state_nxt = LED_TX;
      else state_nxt = RST_TX;
    end

    if (state_nxt == READY && state != READY)
      retry_nxt = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state  <= RST_TX;
      timer  <= '0;
      retry  <= '0;
      mask_q <= '0;
    end else begin
      state  <= state_nxt;
      retry  <= retry_nxt;
      mask_q <= mask_nxt;
      if (state_nxt != state) timer <= '0;
      else if (is_wait) timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      ps2.ps2_cmd  <= 8'h00;
      ps2.ps2_send <= 1'b0;
      led_ack      <= 1'b0;
      key_data     <= 8'h00;
      key_valid    <= 1'b0;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      ps2.ps2_cmd  <= cmd_nxt;
      ps2.ps2_send <= send_nxt;
      led_ack      <= ack_nxt;
      key_valid    <= fwd;
      if (fwd) key_data <= ps2.ps2_rx_data;
      ready        <= (state_nxt == READY);
      fail         <= (state_nxt == FAIL);
    end
  end

endmodule
